axi_test_m_s: RTL and testbench

Self-checking AXI4-Lite loopback block: an internal AXI4-Lite master writes a known data pattern into an internal AXI4-Lite slave register file, reads it back, and compares. It is a bring-up/diagnostic block sitting at the top of a test design. It exposes only a start input and done/error status outputs.

---
 rtl/axi_test_pkg.sv | 15 +
 rtl/axi_lite_slave_regs.sv | 95 +++++++++
 rtl/axi_test_m_s.sv | 171 +++++++++++++++++
 tb/tb_axi_test_m_s.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/axi_test_pkg.sv
// Shared types and constants for the AXI4-Lite loopback self-test block.
package axi_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_COMPARE
    } state_t;

    localparam logic [1:0]  RESP_OKAY          = 2'b00;
    localparam logic [1:0]  RESP_SLVERR        = 2'b10;
    localparam logic [31:0] DEFAULT_START_DATA = 32'hAA00_0000;

endpackage

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register file with single-outstanding handshakes per channel.
module axi_lite_slave_regs
    import axi_test_pkg::*;
#(
    parameter int C_NUM_WORDS  = 4,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 6
) (
    input  logic                      axi_aclk,
    input  logic                      axi_areset,
    input  logic [C_ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]                awprot,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [C_DATA_WIDTH-1:0]   wdata,
    input  logic [C_DATA_WIDTH/8-1:0] wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [C_ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]                arprot,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [C_DATA_WIDTH-1:0]   rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready
);

    localparam int XW = C_ADDR_WIDTH - 2;

    logic                                   wr_accept;
    logic                                   wr_hs;
    logic [XW-1:0]                          wr_index;
    logic [XW-1:0]                          rd_index;
    logic [C_DATA_WIDTH-1:0]                wmask;
    logic [C_NUM_WORDS:0][C_DATA_WIDTH-1:0] rd_chain;
    logic                                   unused_ok;

    assign wr_index    = awaddr[C_ADDR_WIDTH-1:2];
    assign rd_index    = araddr[C_ADDR_WIDTH-1:2];
    assign awready     = wr_accept;
    assign wready      = wr_accept;
    assign wr_hs       = awvalid & awready & wvalid & wready;
    assign bresp       = RESP_OKAY;
    assign rresp       = RESP_OKAY;
    assign unused_ok   = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};
    assign rd_chain[0] = '0;

    for (genvar b = 0; b < C_DATA_WIDTH / 8; b++) begin : g_strb
        assign wmask[8*b +: 8] = {8{wstrb[b]}};
    end

    // Unmatched indices contribute zero, so out-of-range reads return 0 and writes are dropped.
    for (genvar g = 0; g < C_NUM_WORDS; g++) begin : g_word
        logic [C_DATA_WIDTH-1:0] word;

        always_ff @(posedge axi_aclk) begin
            if (axi_areset) begin
                word <= '0;
            end else if (wr_hs && wr_index == XW'(g)) begin
                word <= (word & ~wmask) | (wdata & wmask);
            end
        end

        assign rd_chain[g+1] = rd_chain[g] | ((rd_index == XW'(g)) ? word : '0);
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            wr_accept <= 1'b0;
            bvalid    <= 1'b0;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
        end else begin
            wr_accept <= ~wr_accept & awvalid & wvalid & ~bvalid;
            if (wr_hs) begin
                bvalid <= 1'b1;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
            arready <= ~arready & arvalid & ~rvalid;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= rd_chain[C_NUM_WORDS];
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_test_m_s.sv
// AXI4-Lite loopback self-test: internal master writes a pattern to the slave,
// reads it back and flags any data or response mismatch.
module axi_test_m_s
    import axi_test_pkg::*;
#(
    parameter int                      C_NUM_TRANSACTIONS = 4,
    parameter int                      C_DATA_WIDTH       = 32,
    parameter int                      C_ADDR_WIDTH       = 6,
    parameter logic [C_DATA_WIDTH-1:0] C_START_DATA       = C_DATA_WIDTH'(DEFAULT_START_DATA)
) (
    input  logic axi_aclk,
    input  logic axi_areset,
    input  logic axi_init_axi_txn,
    output logic axi_txn_done,
    output logic axi_error
);

    localparam int            IW       = $clog2(C_NUM_TRANSACTIONS) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(C_NUM_TRANSACTIONS - 1);

    state_t                    state;
    state_t                    state_next;
    logic                      init_q;
    logic                      init_q2;
    logic                      start;
    logic [IW-1:0]             wr_idx;
    logic [IW-1:0]             rd_idx;
    logic                      wr_busy;
    logic                      rd_busy;
    logic                      done_q;
    logic                      error_q;
    logic                      b_hs;
    logic                      r_hs;

    logic [C_ADDR_WIDTH-1:0]   awaddr;
    logic [C_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                awprot;
    logic [2:0]                arprot;
    logic [C_DATA_WIDTH-1:0]   wdata;
    logic [C_DATA_WIDTH-1:0]   rdata;
    logic [C_DATA_WIDTH/8-1:0] wstrb;
    logic [1:0]                bresp;
    logic [1:0]                rresp;
    logic                      awvalid, awready, wvalid, wready, bvalid, bready;
    logic                      arvalid, arready, rvalid, rready;

    assign start        = init_q & ~init_q2;
    assign b_hs         = bvalid & bready;
    assign r_hs         = rvalid & rready;
    assign awaddr       = C_ADDR_WIDTH'({wr_idx, 2'b00});
    assign araddr       = C_ADDR_WIDTH'({rd_idx, 2'b00});
    assign wdata        = C_START_DATA + C_DATA_WIDTH'(wr_idx);
    assign wstrb        = '1;
    assign awprot       = '0;
    assign arprot       = '0;
    assign bready       = (state == ST_WRITE);
    assign rready       = (state == ST_READ);
    assign axi_txn_done = done_q;
    assign axi_error    = error_q;

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Start edges outside IDLE are ignored, so a run is never restarted mid-flight.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_WRITE;
            ST_WRITE:   if (b_hs && wr_idx == LAST_IDX) state_next = ST_READ;
            ST_READ:    if (r_hs && rd_idx == LAST_IDX) state_next = ST_COMPARE;
            ST_COMPARE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            init_q  <= 1'b0;
            init_q2 <= 1'b0;
            wr_idx  <= '0;
            rd_idx  <= '0;
            wr_busy <= 1'b0;
            rd_busy <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            arvalid <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            init_q  <= axi_init_axi_txn;
            init_q2 <= init_q;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        wr_idx  <= '0;
                        rd_idx  <= '0;
                    end
                end
                ST_WRITE: begin
                    if (!wr_busy) begin
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        wr_busy <= 1'b1;
                    end else begin
                        if (awvalid && awready) awvalid <= 1'b0;
                        if (wvalid && wready) wvalid <= 1'b0;
                        if (b_hs) begin
                            wr_busy <= 1'b0;
                            wr_idx  <= wr_idx + 1'b1;
                            if (bresp != RESP_OKAY) error_q <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (!rd_busy) begin
                        arvalid <= 1'b1;
                        rd_busy <= 1'b1;
                    end else begin
                        if (arvalid && arready) arvalid <= 1'b0;
                        if (r_hs) begin
                            rd_busy <= 1'b0;
                            rd_idx  <= rd_idx + 1'b1;
                            if (rresp != RESP_OKAY ||
                                rdata != C_START_DATA + C_DATA_WIDTH'(rd_idx)) begin
                                error_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_COMPARE: done_q <= 1'b1;
                default: ;
            endcase
        end
    end

    axi_lite_slave_regs #(
        .C_NUM_WORDS  (C_NUM_TRANSACTIONS),
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_ADDR_WIDTH (C_ADDR_WIDTH)
    ) u_slave (
        .axi_aclk   (axi_aclk),
        .axi_areset (axi_areset),
        .awaddr     (awaddr),
        .awprot     (awprot),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready),
        .araddr     (araddr),
        .arprot     (arprot),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready)
    );

endmodule

// File: tb/tb_axi_test_m_s.sv
// Directed self-checking bench for the AXI4-Lite loopback block.
module tb_axi_test_m_s;
    import axi_test_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic init  = 1'b0;
    logic done;
    logic err;
    int   total = 0;
    int   bad   = 0;

    axi_test_m_s #(
        .C_NUM_TRANSACTIONS (4),
        .C_DATA_WIDTH       (32),
        .C_ADDR_WIDTH       (6),
        .C_START_DATA       (32'hAA00_0000)
    ) dut (
        .axi_aclk         (clk),
        .axi_areset       (reset),
        .axi_init_axi_txn (init),
        .axi_txn_done     (done),
        .axi_error        (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic applyStimulus(input logic rst, input logic start_level, input int cycles);
        reset = rst;
        init  = start_level;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitForDone(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic startRun(input string tag);
        applyStimulus(0, 0, 2);
        applyStimulus(0, 1, 2);
        checkOutput({tag, "_done_cleared"}, 32'(done), 32'd0);
    endtask

    task automatic runToDone(input string tag, input int budget);
        bit seen;
        waitForDone(budget, seen);
        checkOutput({tag, "_done_in_time"}, 32'(seen), 32'd1);
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, "_reg0"}, dut.u_slave.g_word[0].word, 32'hAA00_0000);
        checkOutput({tag, "_reg1"}, dut.u_slave.g_word[1].word, 32'hAA00_0001);
        checkOutput({tag, "_reg2"}, dut.u_slave.g_word[2].word, 32'hAA00_0002);
        checkOutput({tag, "_reg3"}, dut.u_slave.g_word[3].word, 32'hAA00_0003);
    endtask

    task automatic checkIdleBus(input string tag);
        checkOutput({tag, "_done"},    32'(done),        32'd0);
        checkOutput({tag, "_err"},     32'(err),         32'd0);
        checkOutput({tag, "_awvalid"}, 32'(dut.awvalid), 32'd0);
        checkOutput({tag, "_wvalid"},  32'(dut.wvalid),  32'd0);
        checkOutput({tag, "_arvalid"}, 32'(dut.arvalid), 32'd0);
        checkOutput({tag, "_bvalid"},  32'(dut.bvalid),  32'd0);
        checkOutput({tag, "_rvalid"},  32'(dut.rvalid),  32'd0);
        checkOutput({tag, "_state"},   32'(dut.state),   32'(ST_IDLE));
    endtask

    initial begin
        int  drops;
        bit  found;

        // Reset held for 5 cycles, checked during and after.
        applyStimulus(1, 0, 2);
        checkOutput("rst_during_done", 32'(done), 32'd0);
        checkOutput("rst_during_err",  32'(err),  32'd0);
        applyStimulus(1, 0, 3);
        applyStimulus(0, 0, 1);
        checkIdleBus("rst_after");
        checkRegs0: checkOutput("rst_reg0", dut.u_slave.g_word[0].word, 32'h0);

        // Single run with the start input held high; done within 40 cycles of the edge.
        applyStimulus(0, 1, 0);
        runToDone("single", 40);
        checkOutput("single_err", 32'(err), 32'd0);
        checkRegs("single");
        drops = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 1);
            if (!done) drops++;
        end
        checkOutput("single_no_rerun", drops, 32'd0);

        // Retrigger after a short low period.
        $display("[TB] retrigger");
        startRun("retrig");
        runToDone("retrig", 38);
        checkOutput("retrig_err", 32'(err), 32'd0);

        // Reset during the write phase aborts the run immediately.
        $display("[TB] reset mid-run");
        startRun("mrr_pre");
        applyStimulus(0, 1, 1);
        checkOutput("mrr_awvalid_up", 32'(dut.awvalid), 32'd1);
        applyStimulus(1, 0, 1);
        checkIdleBus("mrr_abort");
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 1);
        startRun("mrr_post");
        runToDone("mrr_post", 38);
        checkOutput("mrr_post_err", 32'(err), 32'd0);
        checkRegs("mrr_post");

        // Corrupt one slave word once reads have begun.
        $display("[TB] error injection");
        startRun("errinj");
        found = 1'b0;
        for (int i = 0; i < 38 && !found; i++) begin
            applyStimulus(0, 1, 1);
            if (dut.state == ST_READ) found = 1'b1;
        end
        checkOutput("errinj_reached_read", 32'(found), 32'd1);
        force dut.u_slave.g_word[1].word = 32'hDEAD_BEEF;
        runToDone("errinj", 30);
        checkOutput("errinj_err_set", 32'(err), 32'd1);
        release dut.u_slave.g_word[1].word;
        startRun("errclr");
        checkOutput("errclr_err_cleared", 32'(err), 32'd0);
        runToDone("errclr", 38);
        checkOutput("errclr_err_final", 32'(err), 32'd0);
        checkOutput("errclr_reg1", dut.u_slave.g_word[1].word, 32'hAA00_0001);

        // A second start edge mid-run must not restart: done still lands within 40 cycles.
        $display("[TB] ignored start");
        startRun("ign");
        applyStimulus(0, 1, 8);
        applyStimulus(0, 0, 2);
        applyStimulus(0, 1, 1);
        checkOutput("ign_still_running", 32'(done), 32'd0);
        runToDone("ign", 27);
        checkOutput("ign_err", 32'(err), 32'd0);
        drops = 0;
        for (int i = 0; i < 45; i++) begin
            applyStimulus(0, 1, 1);
            if (!done) drops++;
        end
        checkOutput("ign_single_completion", drops, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
